// File: rtl/bitwise_logic_accum.sv
// rtl/bitwise_logic_accum.sv - registered bitwise function with framed, saturating popcount accumulator
module bitwise_logic_accum #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             last,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    output logic [CNT_W-1:0] sum,
    output logic             sat,
    output logic             sum_valid,
    input  logic             sum_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [1:0]       mode_q;
    logic [1:0]       eff_mode;
    logic [WIDTH-1:0] f;
    logic [CNT_W:0]   pop;
    logic [CNT_W:0]   total;
    logic [CNT_W-1:0] acc;
    logic [CNT_W-1:0] acc_base;
    logic [CNT_W-1:0] acc_next;
    logic             sat_int;
    logic             sat_next;
    logic             accept;

    assign in_ready = (state != HOLD);
    assign accept   = in_valid && in_ready;

    // Bitwise function: the first beat of a frame uses the live mode, later beats the latched one
    always_comb begin
        eff_mode = (state == IDLE) ? mode : mode_q;
        case (eff_mode)
            2'b00:   f = ~(a ^ b);
            2'b01:   f = a ^ b;
            2'b10:   f = a & b;
            default: f = a | b;
        endcase
    end

    // Popcount of the result, one bit wider than the accumulator to expose overflow
    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + {{CNT_W{1'b0}}, f[i]};
        end
    end

    // Saturating accumulate; a beat accepted in IDLE restarts the frame from zero
    always_comb begin
        acc_base = (state == IDLE) ? '0 : acc;
        total    = {1'b0, acc_base} + pop;
        if (total[CNT_W]) begin
            acc_next = '1;
            sat_next = 1'b1;
        end else begin
            acc_next = total[CNT_W-1:0];
            sat_next = (state == IDLE) ? 1'b0 : sat_int;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: last beat closes the frame, sum_ready releases the held sum
    always_comb begin
        state_next = state;
        case (state)
            IDLE, ACCUM: begin
                if (accept) begin
                    state_next = last ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (sum_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath registers: per-beat result, running accumulator, and the held frame total
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y         <= '0;
            y_valid   <= 1'b0;
            acc       <= '0;
            sat_int   <= 1'b0;
            mode_q    <= 2'b00;
            sum       <= '0;
            sat       <= 1'b0;
            sum_valid <= 1'b0;
        end else begin
            y_valid <= accept;
            if (accept) begin
                y       <= f;
                acc     <= acc_next;
                sat_int <= sat_next;
                if (state == IDLE) begin
                    mode_q <= mode;
                end
                if (last) begin
                    sum       <= acc_next;
                    sat       <= sat_next;
                    sum_valid <= 1'b1;
                end
            end
            if (state == HOLD && sum_ready) begin
                sum_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bitwise_logic_accum.sv
// tb/tb_bitwise_logic_accum.sv - directed self-checking bench for bitwise_logic_accum
module tb_bitwise_logic_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        last;
    logic [1:0]  mode;
    logic        sum_ready;

    logic        in_ready;
    logic [7:0]  y;
    logic        y_valid;
    logic [15:0] sum;
    logic        sat;
    logic        sum_valid;

    logic        in_ready6;
    logic [7:0]  y6;
    logic        y_valid6;
    logic [5:0]  sum6;
    logic        sat6;
    logic        sum_valid6;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bitwise_logic_accum #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .last(last), .mode(mode),
        .y(y), .y_valid(y_valid), .sum(sum), .sat(sat),
        .sum_valid(sum_valid), .sum_ready(sum_ready)
    );

    bitwise_logic_accum #(.WIDTH(8), .CNT_W(6)) dut6 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready6),
        .a(a), .b(b), .last(last), .mode(mode),
        .y(y6), .y_valid(y_valid6), .sum(sum6), .sat(sat6),
        .sum_valid(sum_valid6), .sum_ready(sum_ready)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  exp_y;
        logic [15:0] exp_sum;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_beat(input logic [1:0] m, input logic [7:0] av, input logic [7:0] bv, input logic l);
        @(negedge clk);
        in_valid = 1'b1;
        mode     = m;
        a        = av;
        b        = bv;
        last     = l;
        @(posedge clk);
        #1;
    endtask

    task automatic release_sum();
        @(negedge clk);
        in_valid  = 1'b0;
        last      = 1'b0;
        sum_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_sum_valid", {31'b0, sum_valid}, 32'd0);
        check("release_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        sum_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        last      = 1'b0;
        mode      = 2'b00;
        sum_ready = 1'b0;

        vecs[0] = '{2'b00, 8'hF0, 8'hCC, 8'hC3, 16'd4};
        vecs[1] = '{2'b01, 8'hF0, 8'hCC, 8'h3C, 16'd4};
        vecs[2] = '{2'b10, 8'hF0, 8'hCC, 8'hC0, 16'd2};
        vecs[3] = '{2'b11, 8'hF0, 8'hCC, 8'hFC, 16'd6};

        #12;
        check("reset_y", {24'b0, y}, 32'd0);
        check("reset_y_valid", {31'b0, y_valid}, 32'd0);
        check("reset_sum", {16'b0, sum}, 32'd0);
        check("reset_sum_valid", {31'b0, sum_valid}, 32'd0);
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // single-beat frames, one per mode
        for (int i = 0; i < 4; i++) begin
            drive_beat(vecs[i].mode, vecs[i].a, vecs[i].b, 1'b1);
            check($sformatf("t1_y_m%0d", i), {24'b0, y}, {24'b0, vecs[i].exp_y});
            check($sformatf("t1_y_valid_m%0d", i), {31'b0, y_valid}, 32'd1);
            check($sformatf("t1_sum_m%0d", i), {16'b0, sum}, {16'b0, vecs[i].exp_sum});
            check($sformatf("t1_sum_valid_m%0d", i), {31'b0, sum_valid}, 32'd1);
            check($sformatf("t1_sat_m%0d", i), {31'b0, sat}, 32'd0);
            check($sformatf("t1_in_ready_m%0d", i), {31'b0, in_ready}, 32'd0);
            @(negedge clk);
            in_valid = 1'b0;
            @(posedge clk);
            #1;
            check($sformatf("t1_y_valid_pulse_m%0d", i), {31'b0, y_valid}, 32'd0);
            release_sum();
        end

        // back-to-back XNOR frame
        drive_beat(2'b00, 8'hFF, 8'hFF, 1'b0);
        check("t2_y0", {24'b0, y}, 32'hFF);
        check("t2_yv0", {31'b0, y_valid}, 32'd1);
        drive_beat(2'b00, 8'h00, 8'hFF, 1'b0);
        check("t2_y1", {24'b0, y}, 32'h00);
        check("t2_yv1", {31'b0, y_valid}, 32'd1);
        drive_beat(2'b00, 8'hAA, 8'hA5, 1'b1);
        check("t2_y2", {24'b0, y}, 32'hF0);
        check("t2_sum", {16'b0, sum}, 32'd12);
        check("t2_sat", {31'b0, sat}, 32'd0);
        check("t2_sum_valid", {31'b0, sum_valid}, 32'd1);
        check("t2_in_ready", {31'b0, in_ready}, 32'd0);

        // backpressure while the source keeps offering beats
        @(negedge clk);
        in_valid = 1'b1;
        a        = 8'hFF;
        b        = 8'hFF;
        last     = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("t3_sum_c%0d", c), {16'b0, sum}, 32'd12);
            check($sformatf("t3_sum_valid_c%0d", c), {31'b0, sum_valid}, 32'd1);
            check($sformatf("t3_y_valid_c%0d", c), {31'b0, y_valid}, 32'd0);
            check($sformatf("t3_in_ready_c%0d", c), {31'b0, in_ready}, 32'd0);
        end
        release_sum();
        drive_beat(2'b00, 8'hFF, 8'hFF, 1'b1);
        check("t3_fresh_sum", {16'b0, sum}, 32'd8);
        check("t3_fresh_sat", {31'b0, sat}, 32'd0);
        release_sum();

        // saturation on the narrow accumulator
        for (int k = 0; k < 8; k++) begin
            drive_beat(2'b00, 8'hFF, 8'hFF, (k == 7));
        end
        check("t4_sum6", {26'b0, sum6}, 32'd63);
        check("t4_sat6", {31'b0, sat6}, 32'd1);
        check("t4_sum_valid6", {31'b0, sum_valid6}, 32'd1);
        check("t4_sum16", {16'b0, sum}, 32'd64);
        check("t4_sat16", {31'b0, sat}, 32'd0);
        release_sum();
        drive_beat(2'b00, 8'h01, 8'h01, 1'b1);
        check("t4_next_sum6", {26'b0, sum6}, 32'd8);
        check("t4_next_sat6", {31'b0, sat6}, 32'd0);
        release_sum();

        // mode change mid-frame is ignored
        drive_beat(2'b00, 8'h0F, 8'h0F, 1'b0);
        check("t5_y0", {24'b0, y}, 32'hFF);
        drive_beat(2'b10, 8'h00, 8'h00, 1'b1);
        check("t5_y1", {24'b0, y}, 32'hFF);
        check("t5_sum", {16'b0, sum}, 32'd16);
        release_sum();

        // asynchronous reset in the middle of a frame
        drive_beat(2'b00, 8'hFF, 8'hFF, 1'b0);
        drive_beat(2'b00, 8'hFF, 8'hFF, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_y", {24'b0, y}, 32'd0);
        check("t6_rst_y_valid", {31'b0, y_valid}, 32'd0);
        check("t6_rst_sum", {16'b0, sum}, 32'd0);
        check("t6_rst_sum_valid", {31'b0, sum_valid}, 32'd0);
        check("t6_rst_in_ready", {31'b0, in_ready}, 32'd1);
        #1;
        rst = 1'b0;
        drive_beat(2'b00, 8'h0F, 8'h00, 1'b1);
        check("t6_sum", {16'b0, sum}, 32'd4);
        check("t6_sat", {31'b0, sat}, 32'd0);
        check("t6_sum_valid", {31'b0, sum_valid}, 32'd1);
        release_sum();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bitwise_logic_accum.md
Name: bitwise_logic_accum

Overview:
- Parametrised, registered successor to the single-bit XNOR gate.
- Applies a selectable bitwise function (XNOR/XOR/AND/OR) to WIDTH-bit operand streams under a valid/ready handshake and registers the per-beat result.
- Accumulates the popcount of the results over a frame delimited by `last`, then holds the frame sum with a saturation flag until downstream accepts it.
- Sits between a streaming source and a match-count/correlation consumer.

Parameters:
- WIDTH, 8, operand and result width in bits (>=1).
- CNT_W, 16, accumulator width in bits (>= clog2(WIDTH+1)).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  source presents a beat.
- in_ready  out  1  block can accept a beat.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- last  in  1  beat is the final beat of the frame.
- mode  in  2  function select: 00 XNOR, 01 XOR, 10 AND, 11 OR.
- y  out  WIDTH  registered bitwise result of the last accepted beat.
- y_valid  out  1  one-cycle pulse; y is updated.
- sum  out  CNT_W  frame popcount total, saturating.
- sat  out  1  frame total exceeded 2^CNT_W-1; qualified by sum_valid.
- sum_valid  out  1  sum/sat hold a completed frame.
- sum_ready  in  1  consumer accepts sum.

Behaviour:
- Reset, asynchronous and active-high, takes effect immediately regardless of clk:
  - state=IDLE.
  - y=0, y_valid=0, sum=0, sat=0, sum_valid=0, accumulator=0, latched mode=00.
  - Any partial frame is discarded.
- States:
  - IDLE: no frame open.
  - ACCUM: frame open.
  - HOLD: sum presented.
- in_ready = (state != HOLD), combinational from state only.
- A beat is accepted on a rising edge with in_valid && in_ready.
- Function of an accepted beat:
  - In IDLE, the mode input is used and latched for the frame.
  - In ACCUM, the latched mode is used; mode changes mid-frame are ignored.
- Result latency: y <= f(a,b) at the accepting edge; y_valid=1 for exactly the following cycle, 0 otherwise. Back-to-back beats give continuous y_valid.
- Accumulation: p = popcount(f(a,b)), range 0..WIDTH.
  - First beat (accepted in IDLE): acc <= p, sat_int <= 0.
  - Later beats: acc <= acc + p.
  - If the true sum exceeds 2^CNT_W-1, acc <= 2^CNT_W-1 and sat_int <= 1. Sticky for the frame, never wraps.
- Transitions:
  - IDLE -> ACCUM on an accepted beat with last=0.
  - IDLE or ACCUM -> HOLD on an accepted beat with last=1. A single-beat frame is legal.
  - ACCUM stays in ACCUM on non-last beats.
  - HOLD -> IDLE on a rising edge with sum_ready=1.
- Entering HOLD: sum <= final acc (including the last beat's p), sat <= final sat_int, sum_valid=1 from the next cycle.
- In HOLD:
  - sum, sat and sum_valid are stable while sum_ready=0.
  - in_valid is ignored and no beats are accepted.
  - y_valid stays 0 after the last beat's pulse.
- Leaving HOLD on sum_ready=1:
  - sum_valid=0 and in_ready=1 from the next cycle; no same-cycle accept/release bypass.
  - sum/sat keep their values but are unqualified.
- sum_ready outside HOLD has no effect.
- in_valid with no frame open always starts a new frame.
- Gaps (in_valid=0) inside a frame are allowed; the accumulator holds.

Test Plan:
1. WIDTH=8, a=8'hF0, b=8'hCC, single beat with last=1, once per mode:
   - Required y, one cycle after accept: XNOR 8'hC3, XOR 8'h3C, AND 8'hC0, OR 8'hFC.
   - y_valid is a 1-cycle pulse.
   - sum=4/4/2/6 with sum_valid=1, sat=0.
2. XNOR frame (FF,FF), (00,FF), (AA,A5)+last, back-to-back:
   - y = FF, 00, F0 on consecutive cycles.
   - sum=12 one cycle after the third accept; sat=0; in_ready=0.
3. Backpressure: sum_ready=0 for 5 cycles after test 2 with in_valid=1 and a=b=FF:
   - sum=12 held, sum_valid=1, no y_valid, in_ready=0.
   - Raise sum_ready: sum_valid=0 and in_ready=1 the next cycle.
   - The next frame starts fresh: a single beat FF/FF with last gives sum=8.
4. CNT_W=6, XNOR, 8 beats a=b=8'hFF (true total 64):
   - sum=63, sat=1.
   - A following one-beat frame a=b=8'h01 gives sum=8, sat=0.
5. Frame started with mode=XNOR, mode switched to AND after beat 1, beats (0F,0F), (00,00)+last:
   - y=FF for both beats; sum=16.
6. Reset mid-frame:
   - Two XNOR beats (FF,FF), then assert rst between clock edges.
   - Outputs go to 0 immediately; in_ready=1.
   - After deassert, a single beat (0F,00)+last in XNOR gives sum=4, sat=0.
